// File: rtl/mem_clear_sequencer.sv
// Memory initialiser: sweeps 0..DEPTH-1 with a fill pattern while holding
// the core in reset, then holds HOLD cycles and passes the core port through.
// Ports:
//   clk_sys, RESET (sync, active-high): clock and unmaskable reset source
//   rst_src/rst_mask: level reset requests and their ignore mask
//   fill_mode: 0 FILL, 1 FILL^addr, 2 skip sweep, 3 as 0
//   mem_wait: stalls the pending clear write
//   core_*: core memory port, forwarded only in RUN
//   mem_*: memory port; core_reset, done, busy, progress: status
module mem_clear_sequencer #(
  parameter int          AW    = 21,
  parameter int          DW    = 8,
  parameter int          DEPTH = 2**AW,
  parameter logic [DW-1:0] FILL = '1,
  parameter int          GAP   = 0,
  parameter int          HOLD  = 16,
  parameter int          NSRC  = 4
) (
  input  logic            clk_sys,
  input  logic            RESET,
  input  logic [NSRC-1:0] rst_src,
  input  logic [NSRC-1:0] rst_mask,
  input  logic [1:0]      fill_mode,
  input  logic            mem_wait,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_din,
  input  logic            core_we,
  input  logic            core_cs,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  output logic            mem_we,
  output logic            mem_cs,
  output logic            core_reset,
  output logic            done,
  output logic            busy,
  output logic [7:0]      progress
);

  localparam int GCW = $clog2(GAP + 2);
  localparam int HCW = $clog2(HOLD + 2);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_GAP,
    S_HOLD,
    S_RUN
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           req_q;
  logic           done_q;
  logic           req;
  logic [DW-1:0]  pat;
  logic [7:0]     prog_w;

  assign req = RESET | (|(rst_src & ~rst_mask));

  always_comb begin
    pat = FILL;
    unique case (fill_mode)
      2'd1:    pat = FILL ^ DW'(addr_q);
      default: pat = FILL;
    endcase
  end

  assign prog_w = 8'(64'(addr_q) * 64'd256 / 64'(DEPTH));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    gap_d      = gap_q;
    hold_d     = hold_q;
    mem_addr   = '0;
    mem_din    = '0;
    mem_we     = 1'b0;
    mem_cs     = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b1;
    progress   = prog_w;
    unique case (state_q)
      S_CLEAR: begin
        if (!req_q) begin
          if (addr_q == '0 && fill_mode == 2'd2) begin
            // the skipped sweep cycle counts as the first hold cycle
            state_d = S_HOLD;
            hold_d  = HCW'(1);
          end else begin
            mem_cs   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = addr_q;
            mem_din  = pat;
            if (!mem_wait) begin
              if (addr_q == LAST) begin
                state_d = S_HOLD;
                hold_d  = '0;
              end else begin
                addr_d = addr_q + AW'(1);
                if (GAP > 0) begin
                  state_d = S_GAP;
                  gap_d   = '0;
                end
              end
            end
          end
        end
      end
      S_GAP: begin
        if (32'(gap_q) + 32'd1 >= 32'(GAP)) begin
          state_d = S_CLEAR;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GCW'(1);
        end
      end
      S_HOLD: begin
        progress = 8'hFF;
        if (32'(hold_q) + 32'd1 >= 32'(HOLD)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      S_RUN: begin
        core_reset = 1'b0;
        busy       = 1'b0;
        progress   = 8'hFF;
        mem_addr   = core_addr;
        mem_din    = core_din;
        mem_we     = core_we;
        mem_cs     = core_cs;
      end
      default: state_d = S_CLEAR;
    endcase
    if (req_q) begin
      state_d = S_CLEAR;
      addr_d  = '0;
      gap_d   = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q <= S_CLEAR;
      addr_q  <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      req_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      req_q   <= req;
      done_q  <= (state_d == S_RUN) && (state_q != S_RUN);
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_mem_clear_sequencer.sv
// Directed bench for mem_clear_sequencer: three instances cover
// plain/xor fill, wait stalls, reset sources, gap pacing and pass-through.
module tb_mem_clear_sequencer;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  rst_src = '0;
  logic [3:0]  rst_mask = '0;
  logic [1:0]  fm0 = 2'd0;
  logic [1:0]  fm1 = 2'd1;
  logic [1:0]  fm2 = 2'd0;
  logic        mem_wait = 1'b0;
  logic [15:0] core_addr = 16'h1234;
  logic [7:0]  core_din = 8'h5A;
  logic        core_we = 1'b1;
  logic        core_cs = 1'b1;

  logic [15:0] a0, a1, a2;
  logic [7:0]  d0, d1, d2;
  logic        we0, we1, we2, cs0, cs1, cs2;
  logic        cr0, cr1, cr2, dn0, dn1, dn2, bz0, bz1, bz2;
  logic [7:0]  pg0, pg1, pg2;

  int total = 0;
  int bad = 0;
  int ea;
  logic [7:0] exp_a [8] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6,
                            8'hA1, 8'hA0, 8'hA3, 8'hA2};

  always #5 clk = ~clk;

  mem_clear_sequencer #(.AW(16), .DW(8), .DEPTH(16), .FILL(8'hFF),
    .GAP(0), .HOLD(4), .NSRC(4)) u0 (
    .clk_sys(clk), .RESET(RESET), .rst_src(rst_src),
    .rst_mask(rst_mask), .fill_mode(fm0), .mem_wait(mem_wait),
    .core_addr(core_addr), .core_din(core_din), .core_we(core_we),
    .core_cs(core_cs), .mem_addr(a0), .mem_din(d0), .mem_we(we0),
    .mem_cs(cs0), .core_reset(cr0), .done(dn0), .busy(bz0),
    .progress(pg0));

  mem_clear_sequencer #(.AW(16), .DW(8), .DEPTH(8), .FILL(8'hA5),
    .GAP(0), .HOLD(2), .NSRC(4)) u1 (
    .clk_sys(clk), .RESET(RESET), .rst_src(rst_src),
    .rst_mask(rst_mask), .fill_mode(fm1), .mem_wait(mem_wait),
    .core_addr(core_addr), .core_din(core_din), .core_we(core_we),
    .core_cs(core_cs), .mem_addr(a1), .mem_din(d1), .mem_we(we1),
    .mem_cs(cs1), .core_reset(cr1), .done(dn1), .busy(bz1),
    .progress(pg1));

  mem_clear_sequencer #(.AW(16), .DW(8), .DEPTH(4), .FILL(8'h3C),
    .GAP(2), .HOLD(3), .NSRC(4)) u2 (
    .clk_sys(clk), .RESET(RESET), .rst_src(rst_src),
    .rst_mask(rst_mask), .fill_mode(fm2), .mem_wait(mem_wait),
    .core_addr(core_addr), .core_din(core_din), .core_we(core_we),
    .core_cs(core_cs), .mem_addr(a2), .mem_din(d2), .mem_we(we2),
    .mem_cs(cs2), .core_reset(cr2), .done(dn2), .busy(bz2),
    .progress(pg2));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    // reset state with core inputs active
    repeat (3) tick();
    chk("rst_core_reset", 32'(cr0), 32'd1);
    chk("rst_busy", 32'(bz0), 32'd1);
    chk("rst_done", 32'(dn0), 32'd0);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_cs", 32'(cs0), 32'd0);
    chk("rst_addr", 32'(a0), 32'd0);
    chk("rst_progress", 32'(pg0), 32'd0);
    RESET = 1'b0;

    // full sweep; core writes during clear must not leak
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k <= 16) begin
        chk("t1_we", 32'(we0), 32'd1);
        chk("t1_addr", 32'(a0), 32'(k - 1));
        chk("t1_din", 32'(d0), 32'hFF);
      end else if (k <= 20) begin
        chk("t1_hold_we", 32'(we0), 32'd0);
      end else begin
        chk("t6_pass_we", 32'(we0), 32'd1);
        chk("t6_pass_addr", 32'(a0), 32'h1234);
      end
      chk("t1_core_reset", 32'(cr0), 32'(k < 21));
      chk("t1_done", 32'(dn0), 32'(k == 21));
      if (k == 9) chk("t1_progress_mid", 32'(pg0), 32'h80);
      if (k == 17) chk("t1_progress_hold", 32'(pg0), 32'hFF);
      if (k == 20) chk("t1_busy_hold", 32'(bz0), 32'd1);
      if (k == 22) chk("t1_busy_run", 32'(bz0), 32'd0);
      if (k <= 8) begin
        chk("t2_din", 32'(d1), 32'(exp_a[k-1]));
        chk("t2_addr", 32'(a1), 32'(k - 1));
      end else if (k <= 10) begin
        chk("t2_hold_we", 32'(we1), 32'd0);
      end
      chk("t2_done", 32'(dn1), 32'(k == 11));
      if (k <= 13) begin
        chk("t5_gap_we", 32'(we2),
            32'((k % 3 == 1) && (k <= 10)));
        if ((k % 3 == 1) && (k <= 10))
          chk("t5_gap_addr", 32'(a2), 32'((k - 1) / 3));
      end
      chk("t5_gap_core_reset", 32'(cr2), 32'(k < 14));
    end

    // mem_wait stall at address 5
    core_we = 1'b0;
    core_cs = 1'b0;
    do_reset();
    ea = 0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      mem_wait = (k >= 6 && k <= 8);
      chk("t3_we", 32'(we0), 32'(ea < 16));
      if (ea < 16) begin
        chk("t3_addr", 32'(a0), 32'(ea));
        chk("t3_din", 32'(d0), 32'hFF);
      end
      chk("t3_core_reset", 32'(cr0), 32'(k < 24));
      if (!mem_wait && ea < 16) ea++;
    end
    mem_wait = 1'b0;

    // rst_src[1] mid-sweep restarts; masked copy is ignored
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 10) begin
        chk("t4_pre_addr", 32'(a0), 32'd9);
        rst_src = 4'b0010;
      end
      if (k == 11) begin
        chk("t4_req_we", 32'(we0), 32'd0);
        rst_src = 4'b0000;
      end
      if (k == 12) chk("t4_restart_addr0", {a0, 15'd0, we0}, 32'h1);
      if (k == 13) chk("t4_restart_addr1", {a0, 15'd0, we0}, 32'h10001);
    end
    rst_mask = 4'b0010;
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) rst_src = 4'b0010;
      if (k == 11) begin
        chk("t4_mask_addr", {a0, 15'd0, we0}, 32'h000A0001);
        rst_src = 4'b0000;
      end
    end
    rst_mask = 4'b0000;

    // skip sweep
    fm0 = 2'd2;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t5_skip_we", 32'(we0), 32'd0);
      chk("t5_skip_core_reset", 32'(cr0), 32'(k < 5));
      chk("t5_skip_done", 32'(dn0), 32'(k == 5));
    end
    fm0 = 2'd0;

    // combinational pass-through in RUN
    core_addr = 16'h1234;
    core_din = 8'h5A;
    core_we = 1'b1;
    core_cs = 1'b1;
    #1;
    chk("t6_addr", 32'(a0), 32'h1234);
    chk("t6_din", 32'(d0), 32'h5A);
    chk("t6_we", 32'(we0), 32'd1);
    chk("t6_cs", 32'(cs0), 32'd1);
    core_addr = 16'h0042;
    core_din = 8'h33;
    core_we = 1'b0;
    #1;
    chk("t6_addr2", 32'(a0), 32'h0042);
    chk("t6_din2", 32'(d0), 32'h33);
    chk("t6_we2", 32'(we0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
